// File: rtl/move_arbiter_pkg.sv
// Shared types and constants for the tic-tac-toe move arbiter.
// FSM state encoding, player encoding and board coordinate range.
package move_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic {
        PLAYER_O = 1'b0,
        PLAYER_X = 1'b1
    } player_e;

    localparam int         NUM_CELLS = 9;
    localparam logic [3:0] COORD_MIN = 4'd1;
    localparam logic [3:0] COORD_MAX = 4'd9;
    localparam logic [3:0] COUNT_MAX = 4'd9;

    // A cell is playable when it is on the board and not yet occupied.
    function automatic logic cell_free(
        input logic [3:0]           coord,
        input logic [NUM_CELLS-1:0] occ
    );
        logic free;
        free = 1'b0;
        if (coord >= COORD_MIN && coord <= COORD_MAX) begin
            for (int k = 0; k < NUM_CELLS; k++) begin
                if (coord == 4'(k + 1)) begin
                    free = ~occ[k];
                end
            end
        end
        return free;
    endfunction

endpackage

// File: rtl/click_edge_detect.sv
// Optional synchroniser plus rising-edge detector for one player's click.
// The coordinate travels through the same stages so it stays aligned.
module click_edge_detect #(
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       click_i,
    input  logic [3:0] coord_i,
    output logic       edge_o,
    output logic [3:0] coord_o
);

    logic       click_s;
    logic       prev_q;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign click_s = click_i;
            assign coord_o = coord_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0]      clk_pipe_q;
            logic [SYNC_STAGES-1:0][3:0] crd_pipe_q;

            // Shift click and coordinate through the synchroniser chain.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    clk_pipe_q <= '0;
                    crd_pipe_q <= '0;
                end else begin
                    clk_pipe_q[0] <= click_i;
                    crd_pipe_q[0] <= coord_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        clk_pipe_q[i] <= clk_pipe_q[i-1];
                        crd_pipe_q[i] <= crd_pipe_q[i-1];
                    end
                end
            end

            assign click_s = clk_pipe_q[SYNC_STAGES-1];
            assign coord_o = crd_pipe_q[SYNC_STAGES-1];
        end
    endgenerate

    // Remember the previous click sample for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= click_s;
        end
    end

    assign edge_o = click_s & ~prev_q;

endmodule

// File: rtl/move_arbiter.sv
// Turn arbiter between a local (O) and remote (X) player.
// Validates clicked cells, strobes committed moves, enforces a lockout.
module move_arbiter
    import move_arbiter_pkg::*;
#(
    parameter int unsigned FIRST_PLAYER   = 0,
    parameter int unsigned LOCKOUT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       globalReset,
    input  logic       roundReset,
    input  logic       o_click,
    input  logic [3:0] o_coord,
    input  logic       x_click,
    input  logic [3:0] x_coord,
    input  logic [8:0] o_status,
    input  logic [8:0] x_status,
    input  logic       game_over,
    output logic       move_valid,
    output logic       move_player,
    output logic [3:0] move_coord,
    output logic       reject,
    output logic       wrong_turn,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       round_done
);

    localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCKOUT_CYCLES - 1);
    localparam logic FIRST = 1'(FIRST_PLAYER);

    state_e        state_q, state_d;
    logic          turn_q, turn_d;
    logic          starter_q;
    logic [3:0]    count_q, count_d;
    logic [3:0]    coord_q, coord_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reject_q, reject_d;
    logic          wrong_q, wrong_d;

    logic          edge_rst;
    logic          o_edge, x_edge;
    logic [3:0]    o_crd, x_crd;
    logic          own_edge, other_edge;
    logic [3:0]    own_crd;

    assign edge_rst = globalReset | roundReset;

    click_edge_detect #(.SYNC_STAGES(0)) u_o_edge (
        .clk_i   (clock),
        .rst_i   (edge_rst),
        .click_i (o_click),
        .coord_i (o_coord),
        .edge_o  (o_edge),
        .coord_o (o_crd)
    );

    click_edge_detect #(.SYNC_STAGES(2)) u_x_edge (
        .clk_i   (clock),
        .rst_i   (edge_rst),
        .click_i (x_click),
        .coord_i (x_coord),
        .edge_o  (x_edge),
        .coord_o (x_crd)
    );

    assign own_edge   = (turn_q == PLAYER_X) ? x_edge : o_edge;
    assign other_edge = (turn_q == PLAYER_X) ? o_edge : x_edge;
    assign own_crd    = (turn_q == PLAYER_X) ? x_crd  : o_crd;

    // State and datapath registers; full reset beats new-round reset.
    always_ff @(posedge clock) begin
        if (globalReset) begin
            state_q   <= ST_WAIT;
            turn_q    <= FIRST;
            starter_q <= FIRST;
            count_q   <= '0;
            coord_q   <= '0;
            cnt_q     <= '0;
            reject_q  <= 1'b0;
            wrong_q   <= 1'b0;
        end else if (roundReset) begin
            state_q   <= ST_WAIT;
            turn_q    <= ~starter_q;
            starter_q <= ~starter_q;
            count_q   <= '0;
            coord_q   <= '0;
            cnt_q     <= '0;
            reject_q  <= 1'b0;
            wrong_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            count_q   <= count_d;
            coord_q   <= coord_d;
            cnt_q     <= cnt_d;
            reject_q  <= reject_d;
            wrong_q   <= wrong_d;
        end
    end

    // Next-state and datapath update for the move FSM.
    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        count_d  = count_q;
        coord_d  = coord_q;
        cnt_d    = cnt_q;
        reject_d = 1'b0;
        wrong_d  = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (own_edge) begin
                    coord_d = own_crd;
                    state_d = ST_CHECK;
                end
                if (other_edge) begin
                    wrong_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (cell_free(coord_q, o_status | x_status)) begin
                    state_d = ST_ISSUE;
                end else begin
                    reject_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (cnt_q == CNT_LAST) begin
                    count_d = (count_q == COUNT_MAX) ? COUNT_MAX
                                                     : count_q + 4'd1;
                    turn_d  = ~turn_q;
                    state_d = (game_over || count_d == COUNT_MAX) ? ST_DONE
                                                                 : ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Outputs decoded from state and registered strobes.
    always_comb begin
        move_valid  = (state_q == ST_ISSUE);
        move_player = turn_q;
        move_coord  = coord_q;
        reject      = reject_q;
        wrong_turn  = wrong_q;
        turn        = turn_q;
        move_count  = count_q;
        round_done  = (state_q == ST_DONE);
    end

endmodule
